grid_reader: RTL and testbench

- Host-side reader that requests and serially streams the finished solution out of the grid.
- Waits for the grid to finish, then walks all cells in row-major order through the grid's indexed read port.
- Converts each one-hot cell value to binary and emits it on a valid/ready stream with a last marker.
- Sits beside the grid, between the generator core and any host/UART/test consumer.

---
 rtl/grid_pkg.sv | 41 ++++
 rtl/grid_reader_if.sv | 24 ++
 rtl/grid_reader_fifo.sv | 61 ++++++
 rtl/grid_reader.sv | 139 +++++++++++++
 tb/tb_grid_reader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_pkg.sv
// Grid dimensions, reader state encoding and the one-hot cell decoder.
// The reader, display and debug code all import this package.
package grid_pkg;

  localparam int GRID_ORD = 3;
  localparam int LEN      = GRID_ORD * GRID_ORD;
  localparam int AREA     = LEN * LEN;
  localparam int VAL_W    = $clog2(LEN);
  localparam int IDX_W    = $clog2(AREA);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } reader_state_t;

  typedef struct packed {
    logic             bad;
    logic [VAL_W-1:0] value;
  } cell_dec_t;

  // Zero or several bits set is reported as bad with value 0.
  function automatic cell_dec_t onehot_decode(input logic [LEN-1:0] onehot);
    cell_dec_t   dec;
    int unsigned ones;
    dec  = '0;
    ones = 0;
    for (int i = 0; i < LEN; i++) begin
      if (onehot[i]) begin
        ones++;
        dec.value = VAL_W'(i);
      end
    end
    if (ones != 1) begin
      dec.value = '0;
      dec.bad   = 1'b1;
    end
    return dec;
  endfunction

endpackage

// File: rtl/grid_reader_if.sv
// Cell read port toward the grid plus the valid/ready output stream.
interface grid_reader_if;

  logic                       rd_en;
  logic [grid_pkg::IDX_W-1:0] rd_index;
  logic [grid_pkg::LEN-1:0]   rd_onehot;

  logic                       out_valid;
  logic                       out_ready;
  logic [grid_pkg::VAL_W-1:0] out_value;
  logic                       out_last;
  logic                       out_bad;

  modport master (
    output rd_en, rd_index, out_valid, out_value, out_last, out_bad,
    input  rd_onehot, out_ready
  );

  modport slave (
    input  rd_en, rd_index, out_valid, out_value, out_last, out_bad,
    output rd_onehot, out_ready
  );

endinterface

// File: rtl/grid_reader_fifo.sv
// Small synchronous FIFO for the reader output. Head is read combinationally;
// a push and pop in the same cycle is accepted even when full.
module reader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr];
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & ((count_q != FULL_CNT) | rd_ok);

  // Storage; when full, the slot being written is the one being popped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/grid_reader.sv
// Streams the solved grid out in row-major order once the grid reports success.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RD_IDLE  | waiting for rq_dump with a successful grid
// RD_ISSUE | issuing cell reads, throttled by FIFO credit
// RD_DRAIN | all reads issued, emptying FIFO until the last beat leaves
//
// Reads are credit-limited: FIFO entries plus the read in flight never exceed
// FIFO_DEPTH (minimum 2), and a pop in the same cycle frees one credit so a
// depth of 2 sustains one beat per cycle.
module grid_reader
  import grid_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          grid_done,
  input  logic          grid_success,
  input  logic          rq_dump,
  output logic          busy,
  output logic          dump_done,
  output logic          dump_reject,
  output logic          bad_seen,
  grid_reader_if.master bus
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W   = CNT_W + 1;
  localparam int ENTRY_W = VAL_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(AREA - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  reader_state_t      state_q;
  reader_state_t      state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               inflight_q;
  logic               rsp_last_q;
  logic               accept;
  logic               reject_d;
  logic               done_d;
  logic               rd_fire;
  logic               pop;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [OCC_W-1:0]   occ;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  cell_dec_t          rsp_dec;

  assign rsp_dec  = onehot_decode(bus.rd_onehot);
  assign fifo_din = {rsp_dec.value, rsp_last_q, rsp_dec.bad};
  assign occ      = {1'b0, fifo_count} + OCC_W'(inflight_q);
  assign pop      = bus.out_valid & bus.out_ready;

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_value = fifo_dout[ENTRY_W-1:2];
  assign bus.out_last  = fifo_dout[1];
  assign bus.out_bad   = fifo_dout[0];
  assign bus.rd_en     = rd_fire;
  assign bus.rd_index  = idx_q;
  assign busy          = (state_q != RD_IDLE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RD_IDLE;
    else       state_q <= state_d;
  end

  // Next state, read issue and pulse requests.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject_d = 1'b0;
    done_d   = 1'b0;
    rd_fire  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rq_dump && grid_done) begin
          if (grid_success) begin
            accept  = 1'b1;
            state_d = RD_ISSUE;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        rd_fire = (occ < DEPTH_OCC) || ((occ == DEPTH_OCC) && pop);
        if (rd_fire && (idx_q == LAST_IDX)) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (!inflight_q && (fifo_count == CNT_W'(1)) && pop) begin
          state_d = RD_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Read index, in-flight tracking, sticky bad flag and status pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      rsp_last_q  <= 1'b0;
      bad_seen    <= 1'b0;
      dump_done   <= 1'b0;
      dump_reject <= 1'b0;
    end else begin
      dump_done   <= done_d;
      dump_reject <= reject_d;
      inflight_q  <= rd_fire;
      rsp_last_q  <= rd_fire && (idx_q == LAST_IDX);
      if (accept)       idx_q <= '0;
      else if (rd_fire) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      if (accept)                         bad_seen <= 1'b0;
      else if (inflight_q && rsp_dec.bad) bad_seen <= 1'b1;
    end
  end

  reader_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_grid_reader.sv
// Bench for grid_reader: grid read-port model, stream monitor, reference
// beat list derived from the cell contents, table vectors and corner sequences.
module tb_grid_reader;
  import grid_pkg::*;

  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic             last;
    logic             bad;
  } beat_t;

  typedef struct {
    int             idx;
    logic [LEN-1:0] oh;
    int             exp_val;
    int             exp_bad;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic grid_done = 1'b0, grid_success = 1'b0, rq_dump = 1'b0;
  logic busy, dump_done, dump_reject, bad_seen;

  grid_reader_if bus();

  grid_reader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .grid_done    (grid_done),
    .grid_success (grid_success),
    .rq_dump      (rq_dump),
    .busy         (busy),
    .dump_done    (dump_done),
    .dump_reject  (dump_reject),
    .bad_seen     (bad_seen),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int rdy_mode = 0;
  int acc_cyc, first_hs_cyc, last_hs_cyc;
  int exp_rd_idx = 0, rd_count = 0, outstanding = 0;
  logic stall_prev = 1'b0, last_hs_prev = 1'b0;
  beat_t stall_beat;
  beat_t got[$];
  logic [LEN-1:0] cells [AREA];
  vec_t vecs [8];

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Grid read port: registered read, data one cycle after rd_en.
  initial bus.rd_onehot = '0;
  always @(posedge clock) if (bus.rd_en) bus.rd_onehot <= cells[bus.rd_index];

  // Consumer ready pattern, changed just after each rising edge.
  initial bus.out_ready = 1'b0;
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (cyc % 3 == 0);
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Stream monitor on the falling edge.
  always @(negedge clock) begin
    beat_t cur;
    logic  hs;
    cyc++;
    if (reset) begin
      stall_prev   = 1'b0;
      last_hs_prev = 1'b0;
      outstanding  = 0;
    end else begin
      cur = {bus.out_value, bus.out_last, bus.out_bad};
      hs  = bus.out_valid & bus.out_ready;
      check("dump_done_pulse", dump_done, last_hs_prev);
      check("occupancy_le_depth", int'(outstanding <= FIFO_DEPTH), 1);
      if (stall_prev) begin
        check("stall_valid_held", bus.out_valid, 1);
        check("stall_data_held", cur, stall_beat);
      end
      if (bus.rd_en) begin
        check("rd_index", bus.rd_index, exp_rd_idx);
        exp_rd_idx++;
        rd_count++;
      end
      if (hs) begin
        if (got.size() == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        got.push_back(cur);
      end
      outstanding  = outstanding + int'(bus.rd_en) - int'(hs);
      last_hs_prev = hs & bus.out_last;
      stall_prev   = bus.out_valid & ~bus.out_ready;
      stall_beat   = cur;
    end
  end

  function automatic beat_t ref_beat(input int i);
    beat_t b;
    b      = '0;
    b.last = (i == AREA - 1);
    if ($countones(cells[i]) == 1) begin
      for (int k = 0; k < LEN; k++)
        if (cells[i] == (LEN'(1) << k)) b.value = VAL_W'(k);
    end else begin
      b.bad = 1'b1;
    end
    return b;
  endfunction

  task automatic load_solution();
    for (int r = 0; r < LEN; r++)
      for (int c = 0; c < LEN; c++)
        cells[r*LEN + c] = LEN'(1) << ((r*GRID_ORD + r/GRID_ORD + c) % LEN);
  endtask

  task automatic pulse_rq();
    @(posedge clock); #1 rq_dump = 1'b1;
    @(posedge clock); #1 rq_dump = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic run_dump(input int mode, input string name);
    int seen;
    got.delete();
    exp_rd_idx   = 0;
    rd_count     = 0;
    rdy_mode     = mode;
    first_hs_cyc = -1;
    pulse_rq();
    @(negedge clock);
    check({name, "_bad_seen_cleared"}, bad_seen, 0);
    seen = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (dump_done) begin seen = 1; break; end
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_beat_count"}, got.size(), AREA);
    check({name, "_read_count"}, rd_count, AREA);
    if (mode == 0) begin
      check({name, "_first_latency"}, first_hs_cyc - acc_cyc, 3);
      check({name, "_back_to_back"}, last_hs_cyc - first_hs_cyc, AREA - 1);
    end
    for (int i = 0; i < got.size() && i < AREA; i++)
      check({name, "_beat"}, got[i], ref_beat(i));
  endtask

  initial begin
    int rej, bsy, any_bad, rd_before;
    vecs[0] = '{5,  9'b000000110, 0, 1};
    vecs[1] = '{0,  9'b000000001, 0, 0};
    vecs[2] = '{10, 9'b100000000, 8, 0};
    vecs[3] = '{20, 9'b000000000, 0, 1};
    vecs[4] = '{30, 9'b000010000, 4, 0};
    vecs[5] = '{40, 9'b111111111, 0, 1};
    vecs[6] = '{79, 9'b000001000, 3, 0};
    vecs[7] = '{80, 9'b010000000, 7, 0};
    load_solution();

    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_dump_done", dump_done, 0);
    check("rst_dump_reject", dump_reject, 0);
    check("rst_bad_seen", bad_seen, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_fields", {bus.out_value, bus.out_last, bus.out_bad}, 0);

    // rq_dump before the grid finishes is ignored
    rd_count = 0; rej = 0; bsy = 0;
    pulse_rq();
    repeat (6) begin @(negedge clock); rej += dump_reject; bsy |= busy; end
    check("notdone_no_reject", rej, 0);
    check("notdone_no_busy", bsy, 0);
    check("notdone_no_reads", rd_count, 0);

    // finished but unsuccessful grid: a single reject pulse
    grid_done = 1'b1; grid_success = 1'b0;
    rd_count = 0; rej = 0; bsy = 0;
    pulse_rq();
    repeat (6) begin @(negedge clock); rej += dump_reject; bsy |= busy; end
    check("reject_pulses", rej, 1);
    check("reject_no_busy", bsy, 0);
    check("reject_no_reads", rd_count, 0);

    grid_success = 1'b1;
    run_dump(0, "full");
    run_dump(1, "bp3");

    // table of bad/edge cell encodings
    foreach (vecs[i]) cells[vecs[i].idx] = vecs[i].oh;
    run_dump(2, "table");
    foreach (vecs[i]) begin
      if (vecs[i].idx < got.size()) begin
        check("table_value", got[vecs[i].idx].value, vecs[i].exp_val);
        check("table_bad", got[vecs[i].idx].bad, vecs[i].exp_bad);
      end else begin
        check("table_beat_missing", 0, 1);
      end
    end
    check("table_bad_seen", bad_seen, 1);
    repeat (5) @(negedge clock);
    check("bad_seen_sticky", bad_seen, 1);
    load_solution();
    run_dump(0, "clean");
    check("clean_bad_seen", bad_seen, 0);

    // rq_dump and grid_done/success falling mid-dump are ignored
    fork
      run_dump(2, "middump");
      begin
        repeat (30) @(posedge clock);
        #1 rq_dump = 1'b1; grid_done = 1'b0; grid_success = 1'b0;
        @(posedge clock); #1 rq_dump = 1'b0;
      end
    join
    rd_before = rd_count;
    repeat (5) @(negedge clock);
    check("middump_no_restart", rd_count, rd_before);
    grid_done = 1'b1; grid_success = 1'b1;

    // asynchronous reset after 40 beats
    got.delete(); exp_rd_idx = 0; rd_count = 0; rdy_mode = 0;
    pulse_rq();
    for (int n = 0; n < 500 && got.size() < 40; n++) @(negedge clock);
    check("reset_reached_40", int'(got.size() >= 40), 1);
    @(posedge clock); #2 reset = 1'b1; #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rd_en", bus.rd_en, 0);
    @(negedge clock); #2 reset = 1'b0;
    run_dump(0, "after_reset");

    // random cell contents with random backpressure
    for (int it = 0; it < 3; it++) begin
      any_bad = 0;
      for (int i = 0; i < AREA; i++) begin
        if ($urandom_range(0, 9) == 0) cells[i] = LEN'($urandom);
        else                           cells[i] = LEN'(1) << $urandom_range(0, LEN - 1);
        if (ref_beat(i).bad) any_bad = 1;
      end
      run_dump(2, "rand");
      check("rand_bad_seen", bad_seen, any_bad);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
